// File: rtl/run_expander_pkg.sv
// Shared widths, FIFO depth and FSM encoding for the run-length expander.
package run_expander_pkg;

   localparam int unsigned SYM_W      = 2;
   localparam int unsigned LEN_W      = 3;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned PAIR_W     = SYM_W + LEN_W;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

endpackage

// File: rtl/run_expander_fifo.sv
// Small FIFO holding accepted {sym, len} run pairs ahead of the expander FSM.
module pair_fifo
   import run_expander_pkg::*;
#(
   parameter int unsigned WIDTH = PAIR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/run_expander.sv
// Expands buffered {symbol, length} run pairs into a ready/valid symbol stream.
module run_expander
   import run_expander_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SYM_W-1:0] in_sym,
   input  logic [LEN_W-1:0] in_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SYM_W-1:0] out_sym,
   output logic             out_last,
   output logic             err_zero
);

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [PAIR_W-1:0] head;
   logic [SYM_W-1:0]  head_sym;
   logic [LEN_W-1:0]  head_len;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [SYM_W-1:0]  sym_q, sym_d;
   logic              err_q, err_d;

   logic              beat;
   logic              head_legal;
   logic              head_zero;
   logic              load;

   pair_fifo #(
      .WIDTH(PAIR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({in_sym, in_len}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign in_ready   = !fifo_full && !rst;
   assign fifo_push  = in_valid && in_ready;
   assign head_sym   = head[LEN_W +: SYM_W];
   assign head_len   = head[LEN_W-1:0];
   assign head_legal = !fifo_empty && (head_len != '0);
   assign head_zero  = !fifo_empty && (head_len == '0);
   assign beat       = (state_q == EMIT) && out_ready;

   // Zero-length pairs are dropped whenever they reach the head, even mid-run.
   assign fifo_pop = load || head_zero;
   assign err_d    = head_zero;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sym_d   = sym_q;
      load    = 1'b0;
      case (state_q)
         IDLE: load = head_legal;
         EMIT: begin
            if (beat) begin
               if (rem_q == LEN_W'(1)) begin
                  if (head_legal) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     rem_d   = '0;
                  end
               end else begin
                  rem_d = rem_q - LEN_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         state_d = EMIT;
         rem_d   = head_len;
         sym_d   = head_sym;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         sym_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sym_q   <= sym_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = (state_q == EMIT);
   assign out_sym   = sym_q;
   assign out_last  = (state_q == EMIT) && (rem_q == LEN_W'(1));
   assign err_zero  = err_q;

endmodule
